// File: rtl/final_bits_flusher.sv
// Serialises the 0/1/2 final words captured on in_flag_final as MSB-first bytes, then pulses done.
// First byte valid the cycle after the strobe; bytes advance only on out_valid & out_ready, holding otherwise.
module final_bits_flusher #(
   parameter int OUTPUT_BITSTREAM_WIDTH = 16,
   parameter int BYTE_WIDTH             = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_flag_final,
   input  logic [1:0]                        in_flag,
   input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] in_bit_1,
   input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] in_bit_2,
   input  logic                              out_ready,
   output logic                              out_valid,
   output logic [BYTE_WIDTH-1:0]             out_byte,
   output logic                              out_last,
   output logic                              done,
   output logic                              busy,
   output logic                              err
);

   localparam int W     = OUTPUT_BITSTREAM_WIDTH;
   localparam int BPW   = W / BYTE_WIDTH;
   localparam int CNT_W = (2 * BPW > 1) ? $clog2(2 * BPW) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [2*W-1:0]     shreg;
   logic [CNT_W-1:0]   cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      out_last  = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (in_flag_final) begin
               case (in_flag)
                  2'b01, 2'b10: state_nxt = EMIT;
                  default:      state_nxt = DONE;
               endcase
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = (cnt == '0);
            if (out_ready && (cnt == '0)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Gate with out_valid so stale capture contents never leak outside EMIT.
   assign out_byte = out_valid ? shreg[2*W-1 -: BYTE_WIDTH] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_flag_final) begin
                  // Word 2 is zeroed unless flag 10 so it can never reach the stream.
                  shreg <= {in_bit_1, (in_flag == 2'b10) ? in_bit_2 : {W{1'b0}}};
                  cnt   <= (in_flag == 2'b10) ? CNT_W'(2 * BPW - 1) : CNT_W'(BPW - 1);
                  if (in_flag == 2'b11) begin
                     err <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  shreg <= shreg << BYTE_WIDTH;
                  cnt   <= cnt - 1'b1;
               end
               if (in_flag_final) begin
                  err <= 1'b1;
               end
            end
            DONE: begin
               if (in_flag_final) begin
                  err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_final_bits_flusher.sv
// Bench for final_bits_flusher: directed flushes plus random traffic against a byte-queue reference model.
module tb_final_bits_flusher;

   localparam int BPW = 2;

   logic        clk;
   logic        reset;
   logic        in_flag_final;
   logic [1:0]  in_flag;
   logic [15:0] in_bit_1;
   logic [15:0] in_bit_2;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_byte;
   logic        out_last;
   logic        done;
   logic        busy;
   logic        err;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: bytes still owed to the stream, pending done pulse, sticky error.
   logic [7:0] m_q[$];
   bit         m_done;
   bit         m_err;

   final_bits_flusher #(
      .OUTPUT_BITSTREAM_WIDTH(16),
      .BYTE_WIDTH(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_flag_final(in_flag_final),
      .in_flag(in_flag),
      .in_bit_1(in_bit_1),
      .in_bit_2(in_bit_2),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_byte(out_byte),
      .out_last(out_last),
      .done(done),
      .busy(busy),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Compare this cycle's outputs to the model, then advance model and clock together.
   task automatic step();
      bit ev;
      bit idle;
      bit nd;
      ev = (m_q.size() > 0);
      chk("out_valid", 16'(out_valid), 16'(ev));
      chk("out_byte",  16'(out_byte),  ev ? 16'(m_q[0]) : 16'h0);
      chk("out_last",  16'(out_last),  16'(ev && m_q.size() == 1));
      chk("done",      16'(done),      16'(m_done));
      chk("busy",      16'(busy),      16'(ev));
      chk("err",       16'(err),       16'(m_err));
      idle = !ev && !m_done;
      nd   = 1'b0;
      if (ev && out_ready) begin
         void'(m_q.pop_front());
         if (m_q.size() == 0) nd = 1'b1;
      end
      if (in_flag_final) begin
         if (idle) begin
            case (in_flag)
               2'b00: nd = 1'b1;
               2'b01: for (int b = BPW - 1; b >= 0; b--) m_q.push_back(in_bit_1[b*8 +: 8]);
               2'b10: begin
                  for (int b = BPW - 1; b >= 0; b--) m_q.push_back(in_bit_1[b*8 +: 8]);
                  for (int b = BPW - 1; b >= 0; b--) m_q.push_back(in_bit_2[b*8 +: 8]);
               end
               default: begin
                  nd    = 1'b1;
                  m_err = 1'b1;
               end
            endcase
         end else begin
            m_err = 1'b1;
         end
      end
      m_done = nd;
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [1:0] flag, input logic [15:0] w1, input logic [15:0] w2);
      in_flag_final = 1'b1;
      in_flag       = flag;
      in_bit_1      = w1;
      in_bit_2      = w2;
      step();
      in_flag_final = 1'b0;
      in_flag       = 2'($urandom_range(0, 3));
      in_bit_1      = 16'($urandom);
      in_bit_2      = 16'($urandom);
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while ((m_q.size() > 0 || m_done) && k < budget) begin
         step();
         k++;
      end
      chk("drain_timeout", 16'(m_q.size() > 0 || m_done), 16'h0);
   endtask

   initial begin
      bit pat[7];
      pat = '{1, 0, 0, 1, 1, 0, 1};
      reset = 1'b1;
      in_flag_final = 1'b0;
      in_flag = 2'b00;
      in_bit_1 = 16'h0;
      in_bit_2 = 16'h0;
      out_ready = 1'b1;
      m_done = 1'b0;
      m_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_byte", 16'(out_byte), 16'h0);
      reset = 1'b0;
      step();

      // Two words, full throughput, then back-to-back one-word flush.
      strobe(2'b10, 16'hABCD, 16'h1234);
      drain(20);
      strobe(2'b01, 16'h00FF, 16'hDEAD);
      drain(20);
      strobe(2'b00, 16'h5555, 16'hAAAA);
      drain(20);

      // Backpressure pattern.
      strobe(2'b10, 16'hABCD, 16'h1234);
      foreach (pat[i]) begin
         out_ready = pat[i];
         step();
      end
      out_ready = 1'b1;
      drain(20);

      // Stray strobe mid-stream, then an illegal flag.
      strobe(2'b10, 16'hABCD, 16'h1234);
      step();
      strobe(2'b01, 16'h9999, 16'h7777);
      drain(20);
      strobe(2'b11, 16'hFFFF, 16'hFFFF);
      drain(20);

      // Asynchronous reset after two bytes have gone out.
      strobe(2'b10, 16'hABCD, 16'h1234);
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", 16'(out_valid), 16'h0);
      chk("arst_byte",  16'(out_byte),  16'h0);
      chk("arst_last",  16'(out_last),  16'h0);
      chk("arst_done",  16'(done),      16'h0);
      chk("arst_busy",  16'(busy),      16'h0);
      chk("arst_err",   16'(err),       16'h0);
      m_q.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      strobe(2'b01, 16'h0F1E, 16'hBEEF);
      drain(20);

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         in_flag_final = ($urandom_range(0, 4) == 0);
         in_flag       = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         in_bit_1      = 16'($urandom);
         in_bit_2      = 16'($urandom);
         out_ready     = ($urandom_range(0, 3) != 0);
         step();
      end
      in_flag_final = 1'b0;
      out_ready = 1'b1;
      drain(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/final_bits_flusher.md
Name: final_bits_flusher

Overview:
- Stage directly downstream of the final-bits generator at the end of the encode flush.
- On a final-flush strobe it captures the generator's flag and its two 16-bit words (out_bit_1, out_bit_2).
- It emits the 0, 1 or 2 valid words as big-endian bytes over a valid/ready stream, marks the last byte and pulses done.
- It absorbs downstream backpressure so the generator output only needs to be valid for the strobe cycle.

Parameters:
- OUTPUT_BITSTREAM_WIDTH, 16, width of each input word; must be a multiple of 8.
- BYTE_WIDTH, 8, width of the output stream.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_flag_final  in  1  one-cycle strobe: generator outputs are valid this cycle.
- in_flag  in  2  00 = no words, 01 = word 1 only, 10 = word 1 then word 2, 11 = illegal.
- in_bit_1  in  OUTPUT_BITSTREAM_WIDTH  first final word.
- in_bit_2  in  OUTPUT_BITSTREAM_WIDTH  second final word.
- out_ready  in  1  downstream accepts the byte this cycle.
- out_valid  out  1  out_byte is valid.
- out_byte  out  BYTE_WIDTH  stream byte, MSB-first within each word.
- out_last  out  1  high with the final byte of the flush.
- done  out  1  one-cycle pulse when the flush completes.
- busy  out  1  high from capture until completion.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, any time including mid-flush):
  - State = IDLE; out_valid = out_last = done = busy = err = 0.
  - out_byte = 0; capture registers = 0; pending bytes are discarded.
- Byte count per word: BPW = OUTPUT_BITSTREAM_WIDTH/8 (2 at default). Total bytes N = 0, BPW or 2*BPW for flag 00/01/10.
- FSM states: IDLE, EMIT, DONE.
- IDLE:
  - busy = 0.
  - When in_flag_final = 1, in_flag, in_bit_1 and in_bit_2 are registered in that cycle.
  - Flag 01 or 10 → EMIT; busy = 1 from the next cycle.
  - Flag 00 → DONE.
  - Flag 11 → DONE with err set; no bytes are emitted.
- EMIT:
  - out_valid = 1. out_byte = the current byte of the shift register (word 1 bytes MSB→LSB, then word 2 bytes).
  - A byte advances only when out_valid & out_ready.
  - out_byte and out_last are held stable while out_ready = 0.
  - The byte counter counts down from N-1. out_last = 1 when counter = 0.
  - The transfer with out_last = 1 → DONE.
- DONE:
  - done = 1 for exactly one cycle; busy = 0; out_valid = 0; next state IDLE.
- Latency:
  - First byte is valid the cycle after the strobe.
  - With out_ready held high, N bytes occupy N consecutive cycles, then done is high for one cycle.
  - Flag 00 gives done one cycle after the strobe.
  - A new strobe is accepted in the cycle after done.
- in_flag_final while in EMIT or DONE: ignored; err is set; the current flush is unaffected.
- out_ready high in IDLE or DONE: no effect.
- in_bit_2 is never emitted for flag 01. Inputs are not sampled except at capture.

Test Plan:
- Flag 10, in_bit_1 = 0xABCD, in_bit_2 = 0x1234, out_ready = 1 → bytes AB, CD, 12, 34 on 4 consecutive cycles starting the cycle after the strobe; out_last only with 34; done the next cycle; err = 0.
- Flag 01, in_bit_1 = 0x00FF, in_bit_2 = 0xDEAD → bytes 00, FF only; out_last with FF; done follows.
- Flag 00 → out_valid never asserts; done one cycle after the strobe; busy never asserts.
- Flag 10 with out_ready toggling 1,0,0,1,1,0,1 → each byte is held stable while out_ready = 0; exactly 4 transfers AB, CD, 12, 34; no drop or duplicate.
- Second strobe during EMIT, plus a separate flag 11 strobe → current stream is unchanged and err goes to 1; flag 11 gives done with no bytes and err = 1.
- Reset asserted asynchronously after the second byte of a flag 10 flush → all outputs 0 immediately; after release a new flag 01 flush emits correctly.
